// File: rtl/rx_bit_timer_ctrl_if.sv
// Handshake bundle between the start-bit detector, the bit timer and the
// receive shift register / buffer.
interface rx_bit_timer_ctrl_if;
  logic start_detected;
  logic abort;
  logic serial_in;
  logic shift_strobe;
  logic packet_done;
  logic busy;
  logic framing_error;
  logic parity_error;

  modport master (
    output start_detected, abort, serial_in,
    input  shift_strobe, packet_done, busy, framing_error, parity_error
  );

  modport slave (
    input  start_detected, abort, serial_in,
    output shift_strobe, packet_done, busy, framing_error, parity_error
  );
endinterface

// File: rtl/rx_bit_timer_ctrl.sv
// Receive bit timer: sequences START/DATA/STOP bit periods and strobes the shift register.
// Optional even-parity phase is enabled by defining RX_PARITY_EN.
module rx_bit_timer_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int SAMPLE_PT    = 5,
  parameter int DATA_BITS    = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  rx_bit_timer_ctrl_if.slave  bus
);

  localparam logic [7:0] CPB = 8'(CLKS_PER_BIT);
  localparam logic [7:0] SPT = 8'(SAMPLE_PT);
  localparam logic [3:0] NDB = 4'(DATA_BITS);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

  state_t     state, state_n;
  logic [7:0] clk_cnt, clk_n, clk_inc;
  logic [3:0] bit_cnt, bit_n;
  logic       fe, fe_n;
  logic       wrap, at_sample;
`ifdef RX_PARITY_EN
  logic       par, par_n;
  logic       pe, pe_n;
`endif

  assign wrap      = (clk_cnt == CPB);
  assign at_sample = (clk_cnt == SPT);
  assign clk_inc   = wrap ? 8'd1 : clk_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      fe      <= 1'b0;
`ifdef RX_PARITY_EN
      par     <= 1'b0;
      pe      <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      clk_cnt <= clk_n;
      bit_cnt <= bit_n;
      fe      <= fe_n;
`ifdef RX_PARITY_EN
      par     <= par_n;
      pe      <= pe_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    clk_n   = clk_cnt;
    bit_n   = bit_cnt;
    fe_n    = fe;
`ifdef RX_PARITY_EN
    par_n   = par;
    pe_n    = pe;
`endif
    case (state)
      IDLE: begin
        clk_n = '0;
        if (bus.start_detected) begin
          state_n = START;
          clk_n   = 8'd1;
          bit_n   = '0;
          fe_n    = 1'b0;
`ifdef RX_PARITY_EN
          par_n   = 1'b0;
          pe_n    = 1'b0;
`endif
        end
      end
      START: begin
        clk_n = clk_inc;
        if (wrap) state_n = DATA;
      end
      DATA: begin
        clk_n = clk_inc;
        if (at_sample) begin
          if (bit_cnt != 4'hF) bit_n = bit_cnt + 4'd1;
`ifdef RX_PARITY_EN
          par_n = par ^ bus.serial_in;
`endif
        end
        if (wrap && bit_cnt == NDB) begin
`ifdef RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        clk_n = clk_inc;
        if (at_sample && (bus.serial_in ^ par)) pe_n = 1'b1;
        if (wrap) state_n = STOP;
      end
`endif
      STOP: begin
        clk_n = clk_inc;
        // The frame ends at the stop-bit sample point, not the end of the bit,
        // so the receiver can resync on an early next start edge.
        if (at_sample) begin
          if (!bus.serial_in) fe_n = 1'b1;
          state_n = DONE;
          clk_n   = '0;
        end
      end
      DONE: begin
        clk_n   = '0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        clk_n   = '0;
      end
    endcase
    if (bus.abort) begin
      state_n = IDLE;
      clk_n   = '0;
      bit_n   = '0;
    end
  end

  assign bus.shift_strobe  = (state == DATA) && at_sample;
  assign bus.packet_done   = (state == DONE);
  assign bus.busy          = (state != IDLE);
  assign bus.framing_error = fe;
`ifdef RX_PARITY_EN
  assign bus.parity_error  = pe;
`else
  assign bus.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_rx_bit_timer_ctrl.sv
// Directed bench for rx_bit_timer_ctrl: nominal, framing error, abort,
// ignored starts, mid-frame reset and (with RX_PARITY_EN) parity frames.
module tb_rx_bit_timer_ctrl;
  logic clk;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

`ifdef RX_PARITY_EN
  localparam int PX = 10;
`else
  localparam int PX = 0;
`endif
  localparam int S = 95 + PX;   // stop-bit sample cycle
  localparam int D = 96 + PX;   // packet_done cycle

  rx_bit_timer_ctrl_if bus();

  rx_bit_timer_ctrl #(.CLKS_PER_BIT(10), .SAMPLE_PT(5), .DATA_BITS(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, c, obs, exp);
    end
  endtask

  task automatic chk_cycle(input int c, input bit es, input bit ed, input bit eb);
    chk("strobe", c, bus.shift_strobe, es);
    chk("done",   c, bus.packet_done,  ed);
    chk("busy",   c, bus.busy,         eb);
  endtask

  task automatic step(input logic s, input logic a, input logic si, input logic r);
    bus.start_detected = s;
    bus.abort          = a;
    bus.serial_in      = si;
    n_rst              = r;
    @(posedge clk);
    #1;
  endtask

  // Expected timing of a frame whose start pulse is in cycle f, truncated after cycle cut.
  function automatic bit e_strobe(int c, int f, int cut);
    return c >= f + 15 && c <= f + 85 && ((c - f - 15) % 10 == 0) && c <= cut;
  endfunction
  function automatic bit e_busy(int c, int f, int cut);
    return c >= f + 1 && c <= f + D && c <= cut;
  endfunction
  function automatic bit e_done(int c, int f, int cut);
    return c == f + D && c <= cut;
  endfunction

  initial begin
    bus.start_detected = 1'b0;
    bus.abort          = 1'b0;
    bus.serial_in      = 1'b1;
    n_rst              = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_cycle(0, 1'b0, 1'b0, 1'b0);
    chk("rst_fe", 0, bus.framing_error, 1'b0);
    chk("rst_pe", 0, bus.parity_error,  1'b0);

    // Nominal frame
    for (int c = 0; c <= D + 4; c++) begin
      chk_cycle(c, e_strobe(c, 0, 9999), e_done(c, 0, 9999), e_busy(c, 0, 9999));
      if (c == D || c == D + 4) chk("nom_fe", c, bus.framing_error, 1'b0);
`ifndef RX_PARITY_EN
      if (c == D) chk("nom_pe", c, bus.parity_error, 1'b0);
`endif
      step(c == 0, 1'b0, 1'b1, 1'b1);
    end

    // Framing error: stop bit low, flag sticky until the next accepted start
    for (int c = 0; c <= D + 20; c++) begin
      chk_cycle(c, e_strobe(c, 0, 9999) || e_strobe(c, D + 14, 9999),
                   e_done(c, 0, 9999),
                   e_busy(c, 0, 9999) || e_busy(c, D + 14, 9999));
      chk("fe_sticky", c, bus.framing_error, (c >= D && c <= D + 14));
      step(c == 0 || c == D + 14, 1'b0, (c == S) ? 1'b0 : 1'b1, 1'b1);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_idle", 0, bus.busy, 1'b0);

    // Abort mid-frame at cycle 40, restart at cycle 50
    for (int c = 0; c <= D + 55; c++) begin
      chk_cycle(c, e_strobe(c, 0, 40) || e_strobe(c, 50, 9999),
                   e_done(c, 0, 40)   || e_done(c, 50, 9999),
                   e_busy(c, 0, 40)   || e_busy(c, 50, 9999));
      step(c == 0 || c == 50, c == 40, 1'b1, 1'b1);
    end

    // Starts during a frame and in DONE are ignored; first IDLE cycle accepts.
    // A second frame is then cut by reset at cycle D+54.
    for (int c = 0; c <= D + 70; c++) begin
      chk_cycle(c, e_strobe(c, 0, 9999) || e_strobe(c, D + 1, D + 54),
                   e_done(c, 0, 9999)   || e_done(c, D + 1, D + 54),
                   e_busy(c, 0, 9999)   || e_busy(c, D + 1, D + 54));
      if (c == D + 55) begin
        chk("rst_mid_fe", c, bus.framing_error, 1'b0);
        chk("rst_mid_pe", c, bus.parity_error,  1'b0);
      end
      step(c == 0 || c == 30 || c == D || c == D + 1, 1'b0, 1'b1, c != D + 54);
    end

`ifdef RX_PARITY_EN
    // Data 1,0,1,1,0,0,0,0 (odd ones); parity bit 0 -> error, 1 -> clean
    for (int pb = 0; pb < 2; pb++) begin
      logic [7:0] bits;
      bits = 8'b0000_1101;
      for (int c = 0; c <= D + 4; c++) begin
        logic si;
        si = 1'b1;
        if (c >= 15 && c <= 85 && ((c - 15) % 10 == 0)) si = bits[(c - 15) / 10];
        if (c == 95) si = pb[0];
        chk_cycle(c, e_strobe(c, 0, 9999), e_done(c, 0, 9999), e_busy(c, 0, 9999));
        if (c == 96 || c == D + 4) chk("par_err", c, bus.parity_error, (pb == 0));
        if (c == D) chk("par_fe", c, bus.framing_error, 1'b0);
        step(c == 0, 1'b0, si, 1'b1);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
